// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM with byte-strobed synchronous write and a
// post-reset clear sweep that writes INIT_VALUE to every entry.
// Optional feature: define LUT_RAM_MP_BYPASS_EN to forward a same-cycle
// write to any read port addressing the same entry.
module lut_ram_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]                          wr_data,
  input  logic [DATA_WIDTH/8-1:0]                        wr_strb,
  input  logic [NUM_RD*((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]                   rd_data,
  output logic                                           init_busy
);

  localparam int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NUM_LANES  = DATA_WIDTH / 8;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic                    init_busy_d;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    clr_last;
  logic                    wr_in_range;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   wr_word;

  assign clr_last    = (32'(clr_idx_q) == 32'(DEPTH - 1));
  assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
  assign wr_fire     = (state_q == RUN) && wr_en && wr_in_range;

  // State, sweep counter and busy flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      init_busy <= init_busy_d;
    end
  end

  // Next-state: sweep until the last entry, then stay in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Next outputs: sweep index advance and registered busy flag
  always_comb begin
    clr_idx_d   = clr_idx_q;
    init_busy_d = (state_d == CLEAR);
    if (state_q == CLEAR) begin
      clr_idx_d = clr_last ? '0 : clr_idx_q + ADDR_WIDTH'(1);
    end
  end

  // Merged write word: strobed lanes from wr_data, others from the old entry
  always_comb begin
    wr_word = '0;
    if (wr_in_range) wr_word = ram[wr_addr];
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (wr_strb[i]) wr_word[i*8 +: 8] = wr_data[i*8 +: 8];
    end
  end

  // Storage: clear sweep has priority, normal writes only in RUN
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      ram[clr_idx_q] <= INIT_VALUE;
    end else if (wr_fire) begin
      ram[wr_addr] <= wr_word;
    end
  end

  // Combinational read ports with busy override and out-of-range zeroing
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      logic [ADDR_WIDTH-1:0] a;
      a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (init_busy) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = INIT_VALUE;
      end else if (32'(a) < 32'(DEPTH)) begin
`ifdef LUT_RAM_MP_BYPASS_EN
        if (wr_fire && (a == wr_addr)) begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_word;
        end else begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[a];
        end
`else
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[a];
`endif
      end
    end
  end

endmodule
